fetch_sequencer: RTL and testbench

Instruction-side counterpart to the instruction decoder. It owns the program counter (PC) and the instruction register, and fetches 32-bit instructions from instruction memory over a req/ack handshake. It presents each instruction to the decoder and updates the PC from the PS, k and state fields of the returned control word. It sits between instruction memory and the decoder/datapath, and is the sole writer of the PC.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer_pc_next.sv | 46 ++++
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: PC-select encodings, FSM states
// and the default reset PC.
package fetch_sequencer_pkg;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REG  = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_EXEC2 = 2'b11
    } fsm_state_t;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Next-PC arithmetic for the four PC-select modes, plus detection of a
// register branch whose target is not word aligned.
module pc_next_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      PS,
    input  logic [63:0]     k,
    input  logic [63:0]     reg_target,
    output logic [PC_W-1:0] pc_next,
    output logic            misalign_hit
);

    logic [63:0] rel_offset_s;
    logic [63:0] br_target_s;

    assign rel_offset_s = k << 2;
    assign br_target_s  = reg_target & ~64'h3;

    // Select the next PC; all sums wrap silently at PC_W bits
    always_comb begin
        pc_next      = pc;
        misalign_hit = 1'b0;
        case (PS)
            PS_HOLD: begin
                pc_next = pc;
            end
            PS_INC: begin
                pc_next = pc + PC_W'(3'd4);
            end
            PS_REG: begin
                pc_next      = br_target_s[PC_W-1:0];
                misalign_hit = !word_aligned(reg_target[1:0]);
            end
            PS_REL: begin
                pc_next = pc + rel_offset_s[PC_W-1:0];
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and instruction register, fetches over a
// req/ack handshake and sequences one or two execute cycles per instruction.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC[PC_W-1:0]
) (
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic            state,
    input  logic [1:0]      PS,
    input  logic [63:0]     k,
    input  logic            next_state,
    input  logic [63:0]     reg_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            misalign
);

    fsm_state_t      fsm_r;
    logic [PC_W-1:0] pc_r;
    logic [31:0]     instr_r;
    logic            misalign_r;
    logic            imem_req_r;
    logic            instr_valid_r;
    logic            state_r;

    logic [PC_W-1:0] pc_next_s;
    logic            misalign_hit_s;

    pc_next_calc #(
        .PC_W(PC_W)
    ) u_pc_next (
        .pc           (pc_r),
        .PS           (PS),
        .k            (k),
        .reg_target   (reg_target),
        .pc_next      (pc_next_s),
        .misalign_hit (misalign_hit_s)
    );

    // Sequencer FSM with its registered handshake and phase outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_r         <= ST_IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= 32'h0;
            misalign_r    <= 1'b0;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            state_r       <= 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    fsm_r         <= ST_FETCH;
                    imem_req_r    <= 1'b1;
                    instr_valid_r <= 1'b0;
                    state_r       <= 1'b0;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_r       <= imem_data;
                        fsm_r         <= ST_EXEC;
                        imem_req_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                        state_r       <= 1'b0;
                    end else begin
                        fsm_r         <= ST_FETCH;
                        imem_req_r    <= 1'b1;
                        instr_valid_r <= 1'b0;
                        state_r       <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (next_state) begin
                        fsm_r         <= ST_EXEC2;
                        imem_req_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                        state_r       <= 1'b1;
                    end else begin
                        pc_r          <= pc_next_s;
                        misalign_r    <= misalign_r | misalign_hit_s;
                        fsm_r         <= ST_FETCH;
                        imem_req_r    <= 1'b1;
                        instr_valid_r <= 1'b0;
                        state_r       <= 1'b0;
                    end
                end
                ST_EXEC2: begin
                    // Second phase always retires; next_state is not consulted
                    pc_r          <= pc_next_s;
                    misalign_r    <= misalign_r | misalign_hit_s;
                    fsm_r         <= ST_FETCH;
                    imem_req_r    <= 1'b1;
                    instr_valid_r <= 1'b0;
                    state_r       <= 1'b0;
                end
                default: begin
                    fsm_r         <= ST_IDLE;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                    state_r       <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = pc_r;
    assign imem_req    = imem_req_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign state       = state_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_r + PC_W'(3'd4);
    assign misalign    = misalign_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, reset corner
// sequences and randomized instructions checked against a PC-rule model.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        state;
    logic [1:0]  PS;
    logic [63:0] k;
    logic        next_state;
    logic [63:0] reg_target;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] cur_pc;
    logic        model_mis;

    typedef struct {
        int          waits;
        logic [31:0] data;
        logic        two;
        logic [1:0]  ps1;
        logic [1:0]  ps2;
        logic [63:0] kv;
        logic [63:0] rtv;
        logic [63:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [11];

    fetch_sequencer #(
        .PC_W     (64),
        .RESET_PC (64'h0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .state       (state),
        .PS          (PS),
        .k           (k),
        .next_state  (next_state),
        .reg_target  (reg_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Next PC from the architectural rules, using plain arithmetic
    function automatic logic [63:0] model_next(input logic [63:0] p, input logic [1:0] sel,
                                               input logic [63:0] kv, input logic [63:0] rtv);
        case (sel)
            2'd0:    return p;
            2'd1:    return p + 64'd4;
            2'd2:    return rtv - (rtv % 64'd4);
            default: return p + kv * 64'd4;
        endcase
    endfunction

    // Fetch and execute one instruction starting from a FETCH cycle
    task automatic run_instr(input int waits, input logic [31:0] d, input logic two,
                             input logic [1:0] ps1, input logic [1:0] ps2,
                             input logic [63:0] kv, input logic [63:0] rtv,
                             input logic [63:0] exp_pc, input logic exp_mis);
        int guard = 0;
        while (imem_req !== 1'b1 && guard < 8) begin
            @(negedge clock);
            guard++;
        end
        chk("req_wait", {63'd0, imem_req}, 64'd1);
        chk("fetch_addr", imem_addr, cur_pc);
        chk("pc_plus4", pc_plus4, cur_pc + 64'd4);
        for (int w = 0; w < waits; w++) begin
            imem_ack  = 1'b0;
            imem_data = $urandom;
            @(negedge clock);
            chk("wait_addr", imem_addr, cur_pc);
            chk("wait_valid", {63'd0, instr_valid}, 64'd0);
            chk("wait_req", {63'd0, imem_req}, 64'd1);
        end
        imem_ack  = 1'b1;
        imem_data = d;
        @(negedge clock);
        imem_ack  = 1'b0;
        imem_data = $urandom;
        chk("exec_valid", {63'd0, instr_valid}, 64'd1);
        chk("exec_state", {63'd0, state}, 64'd0);
        chk("exec_instr", {32'd0, instr}, {32'd0, d});
        next_state = two;
        PS         = ps1;
        k          = kv;
        reg_target = rtv;
        if (two) begin
            @(negedge clock);
            chk("exec2_state", {63'd0, state}, 64'd1);
            chk("exec2_valid", {63'd0, instr_valid}, 64'd1);
            chk("exec2_instr", {32'd0, instr}, {32'd0, d});
            chk("exec2_pc_held", pc, cur_pc);
            next_state = 1'($urandom);
            PS         = ps2;
        end
        @(negedge clock);
        chk("next_addr", imem_addr, exp_pc);
        chk("next_req", {63'd0, imem_req}, 64'd1);
        chk("next_valid", {63'd0, instr_valid}, 64'd0);
        chk("misalign", {63'd0, misalign}, {63'd0, exp_mis});
        PS         = 2'($urandom);
        k          = {$urandom, $urandom};
        reg_target = {$urandom, $urandom};
        next_state = 1'($urandom);
        cur_pc     = exp_pc;
    endtask

    initial begin
        vecs[0]  = '{0, 32'h1111_0000, 1'b0, 2'b10, 2'b00, 64'd0, 64'h100, 64'h100, 1'b0};
        vecs[1]  = '{0, 32'hD61F_0020, 1'b0, 2'b10, 2'b00, 64'd0, 64'h4000, 64'h4000, 1'b0};
        vecs[2]  = '{1, 32'hD61F_0040, 1'b0, 2'b10, 2'b00, 64'd0, 64'h4002, 64'h4000, 1'b1};
        vecs[3]  = '{0, 32'h0000_0001, 1'b0, 2'b10, 2'b00, 64'd0, 64'h200, 64'h200, 1'b1};
        vecs[4]  = '{0, 32'h17FF_FFFC, 1'b0, 2'b11, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'h1F0, 1'b1};
        vecs[5]  = '{2, 32'hD61F_0060, 1'b0, 2'b10, 2'b00, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC,
                     64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
        vecs[6]  = '{0, 32'h9100_0400, 1'b0, 2'b01, 2'b00, 64'd0, 64'd0, 64'h0, 1'b1};
        vecs[7]  = '{0, 32'hA5A5_5A5A, 1'b1, 2'b11, 2'b01, 64'd8, 64'd0, 64'h4, 1'b1};
        vecs[8]  = '{3, 32'h0F0F_F0F0, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'h4, 1'b1};
        vecs[9]  = '{0, 32'hC3C3_3C3C, 1'b1, 2'b01, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h0, 1'b1};
        vecs[10] = '{0, 32'h1400_0010, 1'b0, 2'b11, 2'b00, 64'h40, 64'd0, 64'h100, 1'b1};

        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_data  = 32'h0;
        PS         = 2'b00;
        k          = 64'd0;
        next_state = 1'b0;
        reg_target = 64'd0;
        cur_pc     = 64'h0;
        model_mis  = 1'b0;

        // Reset held three cycles with ack tied high
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_req", {63'd0, imem_req}, 64'd0);
            chk("rst_valid", {63'd0, instr_valid}, 64'd0);
            chk("rst_pc", pc, 64'h0);
            chk("rst_instr", {32'd0, instr}, 64'd0);
        end
        chk("rst_state", {63'd0, state}, 64'd0);
        chk("rst_misalign", {63'd0, misalign}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("first_req", {63'd0, imem_req}, 64'd1);
        chk("first_addr", imem_addr, 64'h0);

        foreach (vecs[i]) begin
            run_instr(vecs[i].waits, vecs[i].data, vecs[i].two, vecs[i].ps1, vecs[i].ps2,
                      vecs[i].kv, vecs[i].rtv, vecs[i].exp_pc, vecs[i].exp_mis);
        end

        // Wait states, then reset coinciding with the ack
        for (int w = 0; w < 3; w++) begin
            imem_ack = 1'b0;
            @(negedge clock);
            chk("mid_wait_addr", imem_addr, 64'h100);
            chk("mid_wait_valid", {63'd0, instr_valid}, 64'd0);
        end
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        reset     = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        chk("mid_rst_instr", {32'd0, instr}, 64'd0);
        chk("mid_rst_req", {63'd0, imem_req}, 64'd0);
        chk("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("mid_rst_pc", pc, 64'h0);
        chk("mid_rst_misalign", {63'd0, misalign}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("refetch_req", {63'd0, imem_req}, 64'd1);
        chk("refetch_addr", imem_addr, 64'h0);
        chk("refetch_instr", {32'd0, instr}, 64'd0);
        cur_pc    = 64'h0;
        model_mis = 1'b0;

        // Randomized instructions against the model
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  ps1;
            logic [1:0]  ps2;
            logic [1:0]  applied;
            logic        two;
            logic [63:0] kv;
            logic [63:0] rtv;
            logic [63:0] exp_pc;
            ps1 = 2'($urandom);
            ps2 = 2'($urandom);
            two = 1'($urandom);
            kv  = ($urandom_range(0, 1) == 0) ? {{48{1'b1}}, 16'($urandom)} : {$urandom, $urandom};
            rtv = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) begin
                rtv = rtv - (rtv % 64'd4);
            end
            applied   = two ? ps2 : ps1;
            exp_pc    = model_next(cur_pc, applied, kv, rtv);
            model_mis = model_mis | ((applied == 2'd2) && (rtv % 64'd4 != 64'd0));
            run_instr($urandom_range(0, 3), $urandom, two, ps1, ps2, kv, rtv, exp_pc, model_mis);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
